vedic_prod_accum: RTL and testbench
===================================

Name: vedic_prod_accum

Overview:
- Downstream consumer of the 3x3 Vedic multiplier. Takes its 6-bit product (0..49) over a valid/ready handshake and accumulates a run of products into a saturating sum, dot-product style.
- A run is armed by a start pulse carrying the run length. The final sum is presented on a valid/ready output port.
- Sits between the combinational multiplier and any result sink or register file.

Parameters:
- ACC_W, 12, accumulator/result width; legal range 6..32. The default cannot overflow for the maximum run (15*49=735).
- CNT_W, 4, width of run-length and product counter; max run = 2^CNT_W-1.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse that arms a run; sampled only in IDLE
- len  input  CNT_W  number of products in the run; sampled with start
- prod  input  6  product from multiplier (ans)
- prod_valid  input  1  prod is valid this cycle
- prod_ready  output  1  block accepts prod this cycle
- busy  output  1  high in ACCUM or DONE
- count  output  CNT_W  products accepted so far in current run
- acc_out  output  ACC_W  accumulated sum
- ovf  output  1  sticky saturation flag for current run
- out_valid  output  1  acc_out/ovf hold the final result
- out_ready  input  1  sink accepts the result

Behaviour:
- Reset (async, rst_n=0): state=IDLE. acc_out=0, count=0, ovf=0, out_valid=0, prod_ready=0, busy=0, latched len=0. Reset mid-run abandons the run with no output.
- Registered outputs: prod_ready, out_valid and busy are decoded from the registered state only. There is no combinational path from prod_valid or out_ready to any output.
- IDLE:
  - prod_ready=0, out_valid=0.
  - start=1 with len!=0: latch len, clear acc_out, count and ovf, go to ACCUM next cycle.
  - start=1 with len==0: clear acc_out and ovf, go directly to DONE (empty run, result 0).
- ACCUM:
  - prod_ready=1.
  - Accept on prod_valid&prod_ready: acc_out <= sat(acc_out+prod), count <= count+1.
  - Saturation: if the true sum exceeds 2^ACC_W-1, acc_out is clamped to all-ones and ovf is set. ovf stays set until the next start.
  - The accept that makes count == latched len moves the state to DONE next cycle. prod_ready drops in that same next cycle, so exactly len products are taken.
  - prod_valid=0 cycles are stalls; state and accumulator hold.
- DONE:
  - out_valid=1; acc_out, ovf and count are held stable.
  - On out_ready=1: return to IDLE next cycle with out_valid=0. acc_out and count keep their last values until the next start.
  - out_ready=0: hold indefinitely.
- start outside IDLE is ignored, including start coinciding with the out_ready handshake in DONE. A new run needs start in IDLE, so there is a minimum 1-cycle IDLE gap between runs.
- Arithmetic: prod is zero-extended to ACC_W. The sum is computed at ACC_W+1 bits, and the MSB drives saturation.
- prod values above 49 are not produced by the multiplier. They are accumulated as-is with no checking.
- count never wraps: the maximum len is 2^CNT_W-1, and the count comparison ends the run first.
- Latency:
  - Single-cycle accumulate per accepted product.
  - out_valid rises 1 cycle after the final accepted product.
  - For len==0, out_valid rises 1 cycle after start.

Test Plan:
- Reset then start with len=3, feeding products 6 (2x3), 49 (7x7), 0 back-to-back. Required: prod_ready high for exactly 3 cycles, then acc_out=55, ovf=0, count=3, out_valid=1 one cycle after the last accept.
- Start with len=2 and insert 3 stall cycles (prod_valid=0) between products 12 and 21. Required: acc_out unchanged during stalls, final acc_out=33. Then hold out_ready=0 for 4 cycles: out_valid and acc_out stay stable; on out_ready=1, next cycle is IDLE.
- Start with len=0. Required: out_valid=1 the next cycle with acc_out=0, ovf=0, count=0, and prod_ready never asserted.
- With ACC_W=8, start with len=6 and feed 49 six times. Required: acc_out saturates at 255 on the 6th accept (true sum 294) and ovf=1. The next run, len=1 with prod=4, gives acc_out=4 and ovf=0.
- Assert rst_n=0 mid-run after 2 of 5 products. Required: outputs immediately at reset values and state IDLE. A subsequent start with len=1 and prod=9 gives acc_out=9.
- Pulse start while in ACCUM and again while in DONE together with out_ready. Required: both ignored, the run completes with the original len, and the block returns to IDLE.

Source files
------------

// File: rtl/vedic_prod_accum.sv
// vedic_prod_accum: saturating accumulator for the 3x3 Vedic multiplier.
// A start pulse arms a run of 'len' products. Each product is taken over a
// valid/ready handshake and added into a clamped sum. The final sum is then
// offered on a valid/ready result port. All handshake outputs are decoded
// from registered state only, so there is no combinational path from
// prod_valid or out_ready to any output.
module vedic_prod_accum #(
    parameter int ACC_W = 12,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [5:0]       prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;

    // One extra bit above the accumulator catches the carry that triggers clamping.
    logic [ACC_W:0]   sum_ext;
    logic [CNT_W-1:0] count_inc;

    assign sum_ext   = {1'b0, acc_q} + {{(ACC_W-5){1'b0}}, prod};
    assign count_inc = count_q + CNT_W'(1);

    // Next-state and datapath decode for the IDLE -> ACCUM -> DONE run sequence.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (prod_valid) begin
                    if (sum_ext[ACC_W]) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum_ext[ACC_W-1:0];
                    end
                    count_d = count_inc;
                    if (count_inc == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    assign prod_ready = (state_q == ACCUM);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign count      = count_q;
    assign acc_out    = acc_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_vedic_prod_accum.sv
// Testbench for vedic_prod_accum. Two instances, at the default 12-bit width and
// at 8 bits, share one stimulus stream so that saturation shows up at the narrow
// width. A run-level model tracks the true unclamped sum and derives each
// instance's expected outputs from it.
module tb_vedic_prod_accum;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [3:0] len = '0;
    logic [5:0] prod = '0;
    logic       prod_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic        prod_ready, busy, ovf, out_valid;
    logic [3:0]  count;
    logic [11:0] acc_out;
    logic        prod_ready8, busy8, ovf8, out_valid8;
    logic [3:0]  count8;
    logic [7:0]  acc_out8;

    int errors = 0;
    int checks = 0;
    int ready_cycles = 0;

    vedic_prod_accum #(.ACC_W(12), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .busy(busy),
        .count(count), .acc_out(acc_out), .ovf(ovf), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    vedic_prod_accum #(.ACC_W(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(prod_ready8), .busy(busy8),
        .count(count8), .acc_out(acc_out8), .ovf(ovf8), .out_valid(out_valid8),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Run-level model: phase 0 = waiting for start, 1 = collecting, 2 = presenting.
    int m_phase = 0;
    int m_sum   = 0;
    int m_cnt   = 0;
    int m_len   = 0;

    // Advance the model one clock using the inputs that are held across the edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_sum   = 0;
            m_cnt   = 0;
            m_len   = 0;
        end else begin
            if (m_phase == 1) ready_cycles++;
            case (m_phase)
                0: if (start) begin
                    m_sum   = 0;
                    m_cnt   = 0;
                    m_len   = int'(len);
                    m_phase = (len == 0) ? 2 : 1;
                end
                1: if (prod_valid) begin
                    m_sum += int'(prod);
                    m_cnt++;
                    if (m_cnt == m_len) m_phase = 2;
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        checkOutput("prod_ready", 32'(prod_ready), 32'(m_phase == 1));
        checkOutput("out_valid",  32'(out_valid),  32'(m_phase == 2));
        checkOutput("busy",       32'(busy),       32'(m_phase != 0));
        checkOutput("count",      32'(count),      32'(m_cnt));
        checkOutput("acc12",      32'(acc_out),    32'((m_sum > 4095) ? 4095 : m_sum));
        checkOutput("ovf12",      32'(ovf),        32'(m_sum > 4095));
        checkOutput("acc8",       32'(acc_out8),   32'((m_sum > 255) ? 255 : m_sum));
        checkOutput("ovf8",       32'(ovf8),       32'(m_sum > 255));
        checkOutput("out_valid8", 32'(out_valid8), 32'(m_phase == 2));
    end

    // Drive one cycle of inputs, let the rising edge take them, settle just after.
    task automatic applyStimulus(input logic s, input logic [3:0] l, input logic [5:0] p,
                                 input logic pv, input logic o_r);
        start      = s;
        len        = l;
        prod       = p;
        prod_valid = pv;
        out_ready  = o_r;
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the bench cannot hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        #1 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset_acc",  32'(acc_out),   32'd0);
        checkOutput("reset_busy", 32'(busy),      32'd0);

        // Run of three back-to-back products: 6 + 49 + 0.
        applyStimulus(1, 3, 0, 0, 0);
        ready_cycles = 0;
        applyStimulus(0, 0, 6, 1, 0);
        applyStimulus(0, 0, 49, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t1_acc",    32'(acc_out),   32'd55);
        checkOutput("t1_count",  32'(count),     32'd3);
        checkOutput("t1_ovf",    32'(ovf),       32'd0);
        checkOutput("t1_valid",  32'(out_valid), 32'd1);
        checkOutput("t1_ready_cycles", 32'(ready_cycles), 32'd3);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);

        // Stalls between products, then back-pressure on the result.
        applyStimulus(1, 2, 0, 0, 0);
        applyStimulus(0, 0, 12, 1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 50, 0, 0);
            checkOutput("t2_stall_acc", 32'(acc_out), 32'd12);
        end
        applyStimulus(0, 0, 21, 1, 0);
        checkOutput("t2_acc", 32'(acc_out), 32'd33);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput("t2_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("t2_hold_acc",   32'(acc_out),   32'd33);
        end
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t2_idle_busy",  32'(busy),      32'd0);
        checkOutput("t2_idle_valid", 32'(out_valid), 32'd0);
        checkOutput("t2_kept_acc",   32'(acc_out),   32'd33);

        // Empty run.
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t3_valid", 32'(out_valid),  32'd1);
        checkOutput("t3_acc",   32'(acc_out),    32'd0);
        checkOutput("t3_count", 32'(count),      32'd0);
        checkOutput("t3_ready", 32'(prod_ready), 32'd0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);

        // Six times 49: the 8-bit instance saturates on the last accept.
        applyStimulus(1, 6, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 49, 1, 0);
        checkOutput("t4_acc8_pre", 32'(acc_out8), 32'd245);
        checkOutput("t4_ovf8_pre", 32'(ovf8),     32'd0);
        applyStimulus(0, 0, 49, 1, 0);
        checkOutput("t4_acc8",  32'(acc_out8), 32'd255);
        checkOutput("t4_ovf8",  32'(ovf8),     32'd1);
        checkOutput("t4_acc12", 32'(acc_out),  32'd294);
        checkOutput("t4_ovf12", 32'(ovf),      32'd0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 0, 4, 1, 0);
        checkOutput("t4b_acc8", 32'(acc_out8), 32'd4);
        checkOutput("t4b_ovf8", 32'(ovf8),     32'd0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);

        // Reset in the middle of a five-product run.
        applyStimulus(1, 5, 0, 0, 0);
        applyStimulus(0, 0, 10, 1, 0);
        applyStimulus(0, 0, 20, 1, 0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t5_acc",   32'(acc_out),    32'd0);
        checkOutput("t5_count", 32'(count),      32'd0);
        checkOutput("t5_busy",  32'(busy),       32'd0);
        checkOutput("t5_ready", 32'(prod_ready), 32'd0);
        prod_valid = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 0, 9, 1, 0);
        checkOutput("t5_acc_after", 32'(acc_out), 32'd9);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);

        // start is ignored in ACCUM and during the DONE handshake.
        applyStimulus(1, 2, 0, 0, 0);
        applyStimulus(1, 7, 5, 1, 0);
        applyStimulus(0, 0, 7, 1, 0);
        checkOutput("t6_acc",   32'(acc_out),   32'd12);
        checkOutput("t6_valid", 32'(out_valid), 32'd1);
        applyStimulus(1, 3, 0, 0, 1);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t6_still_idle", 32'(busy),  32'd0);
        checkOutput("t6_count_kept", 32'(count), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
